stopwatch_ctrl: RTL and testbench

Run/stop/clear controller and tick generator placed directly upstream of the 0–9999 counter in the 4-digit FND counter design. It synchronises and debounces two raw push-buttons and runs a small state machine. It emits a count-enable tick at a fixed rate plus a one-cycle clear pulse, which the counter consumes to advance or zero before its value reaches the FND controller.

---
 rtl/stopwatch_pkg.sv | 29 ++
 rtl/stopwatch_ctrl_btn_debounce.sv | 58 +++++
 rtl/stopwatch_ctrl.sv | 89 ++++++++
 tb/tb_stopwatch_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
// Shared definitions for the stopwatch run/stop/clear controller:
//   - FSM state encoding (STOP, RUN, CLEAR)
//   - tick divider derivation from the clock and tick frequencies
//   - a width helper used to size the prescaler and debounce counters
package stopwatch_pkg;

  typedef logic [1:0] state_t;

  localparam state_t STOP  = 2'd0;
  localparam state_t RUN   = 2'd1;
  localparam state_t CLEAR = 2'd2;

  // Number of system clock cycles per count-enable tick.
  function automatic int calc_div(input int sys_clk_hz, input int tick_hz);
    return sys_clk_hz / tick_hz;
  endfunction

  // ceil(log2(v)), clamped to at least 1 so a counter always has a bit.
  function automatic int clog2w(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// btn_debounce
// Two-flop synchroniser, stability debounce and rising-edge press detect
// for one raw push-button.
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset
//   btn_raw  raw asynchronous button level (active-high)
//   press    one-cycle pulse when the debounced level rises
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int DBC_W = clog2w(DB_CYCLES);

  logic             s1;
  logic             s2;
  logic             db;
  logic             db_q;
  logic [DBC_W-1:0] dbc;

  // dbc counts consecutive cycles where the synchronised level disagrees
  // with the accepted level; any agreeing cycle restarts the count, so a
  // pulse shorter than DB_CYCLES never reaches acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      db   <= 1'b0;
      db_q <= 1'b0;
      dbc  <= '0;
    end else begin
      s1   <= btn_raw;
      s2   <= s1;
      db_q <= db;
      if (s2 != db) begin
        if (dbc == DBC_W'(DB_CYCLES - 1)) begin
          db  <= s2;
          dbc <= '0;
        end else begin
          dbc <= dbc + DBC_W'(1);
        end
      end else begin
        dbc <= '0;
      end
    end
  end

  // Only the press edge matters; releases are deliberately ignored.
  assign press = db & ~db_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
// Run/stop/clear controller and tick generator feeding the 0-9999 counter.
// Ports:
//   clk        system clock, all logic on rising edge
//   rst        asynchronous active-high reset
//   btn_run    raw run/stop button
//   btn_clear  raw clear button
//   run        high while in RUN
//   clear      one-cycle pulse, counter loads 0
//   tick       one-cycle count-enable pulse, once per DIV cycles of RUN
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int SYS_CLK_HZ = 100_000_000,
  parameter int TICK_HZ    = 10,
  parameter int DB_CYCLES  = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_run,
  input  logic btn_clear,
  output logic run,
  output logic clear,
  output logic tick
);

  localparam int DIV   = calc_div(SYS_CLK_HZ, TICK_HZ);
  localparam int PSC_W = clog2w(DIV);

  logic             run_press;
  logic             clear_press;
  state_t           state;
  logic [PSC_W-1:0] psc;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_run),
    .press   (run_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clear (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_clear),
    .press   (clear_press)
  );

  // In STOP a clear press beats a simultaneous run press. In RUN the clear
  // press is dropped outright rather than remembered for later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= STOP;
    end else begin
      case (state)
        STOP: begin
          if (clear_press)    state <= CLEAR;
          else if (run_press) state <= RUN;
        end
        RUN: begin
          if (run_press) state <= STOP;
        end
        CLEAR:   state <= STOP;
        default: state <= STOP;
      endcase
    end
  end

  // The prescaler holds in STOP so a pause keeps the partial tick period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psc <= '0;
    end else begin
      case (state)
        RUN: begin
          if (psc == PSC_W'(DIV - 1)) psc <= '0;
          else                        psc <= psc + PSC_W'(1);
        end
        CLEAR:   psc <= '0;
        default: psc <= psc;
      endcase
    end
  end

  assign run   = (state == RUN);
  assign clear = (state == CLEAR);
  assign tick  = (state == RUN) && (psc == PSC_W'(DIV - 1));

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl
// Directed bench for stopwatch_ctrl with DIV=10, DB_CYCLES=4. A behavioural
// model (window-based debounce, mode + phase counter) is checked against
// the outputs every cycle; hand-computed edge positions pin the model.
module tb_stopwatch_ctrl;

  localparam int SYS_HZ = 100;
  localparam int TK_HZ  = 10;
  localparam int DIV    = 10;
  localparam int DB     = 4;

  logic clk;
  logic rst;
  logic btn_run;
  logic btn_clear;
  logic run;
  logic clear;
  logic tick;

  int n_chk;
  int n_fail;
  logic chk_en;

  stopwatch_ctrl #(
    .SYS_CLK_HZ (SYS_HZ),
    .TICK_HZ    (TK_HZ),
    .DB_CYCLES  (DB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_run   (btn_run),
    .btn_clear (btn_clear),
    .run       (run),
    .clear     (clear),
    .tick      (tick)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 stopped, 1 running, 2 clearing. A debounced level flips once
  // the last DB synchronised samples all disagree with it; synchronised
  // samples lag the raw samples by two edges.
  logic hr[$];
  logic hc[$];
  logic m_db_r, m_dbq_r, m_db_c, m_dbq_c;
  int   m_mode;
  int   m_psc;

  function automatic logic settled(input int b, input logic cur);
    logic all_other;
    logic v;
    all_other = 1'b1;
    for (int j = 2; j <= DB + 1; j++) begin
      v = (b == 0) ? hr[hr.size() - 1 - j] : hc[hc.size() - 1 - j];
      if (v == cur) all_other = 1'b0;
    end
    return all_other ? ~cur : cur;
  endfunction

  always @(posedge clk or posedge rst) begin
    logic rp, cp;
    if (rst) begin
      hr.delete();
      hc.delete();
      for (int i = 0; i < DB + 2; i++) begin
        hr.push_back(1'b0);
        hc.push_back(1'b0);
      end
      m_db_r = 0; m_dbq_r = 0; m_db_c = 0; m_dbq_c = 0;
      m_mode = 0;
      m_psc  = 0;
    end else begin
      rp = m_db_r & ~m_dbq_r;
      cp = m_db_c & ~m_dbq_c;
      if (m_mode == 1)      m_psc = (m_psc + 1) % DIV;
      else if (m_mode == 2) m_psc = 0;
      case (m_mode)
        0:       m_mode = cp ? 2 : (rp ? 1 : 0);
        1:       m_mode = rp ? 0 : 1;
        default: m_mode = 0;
      endcase
      hr.push_back(btn_run);
      hc.push_back(btn_clear);
      if (hr.size() > DB + 2) void'(hr.pop_front());
      if (hc.size() > DB + 2) void'(hc.pop_front());
      m_dbq_r = m_db_r;
      m_dbq_c = m_db_c;
      m_db_r  = settled(0, m_db_r);
      m_db_c  = settled(1, m_db_c);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("run",   int'(run),     (m_mode == 1) ? 1 : 0);
      check("clear", int'(clear),   (m_mode == 2) ? 1 : 0);
      check("tick",  int'(tick),    (m_mode == 1 && m_psc == DIV - 1) ? 1 : 0);
      check("psc",   int'(dut.psc), m_psc);
    end
  end

  // ---------------- driver ----------------
  int run_chg;
  int clr_n;
  int clr_at;
  logic [7:0] tick_q[$];
  logic [7:0] exp_q[$];

  // Called at posedge+1. Drives each button high for *_hold edges (0 = not
  // at all), observes `total` edges and records when things happened,
  // counting edges from 1 (edge 1 is the first that samples the buttons).
  task automatic obs(input int run_hold, input int clr_hold, input int total);
    logic run0;
    run0 = run;
    run_chg = 0; clr_n = 0; clr_at = 0;
    tick_q.delete();
    btn_run   = (run_hold > 0);
    btn_clear = (clr_hold > 0);
    for (int i = 1; i <= total; i++) begin
      @(posedge clk);
      #1;
      if (run != run0 && run_chg == 0) run_chg = i;
      if (clear) begin
        clr_n++;
        if (clr_at == 0) clr_at = i;
      end
      if (tick) tick_q.push_back(8'(i));
      if (i == run_hold) btn_run = 1'b0;
      if (i == clr_hold) btn_clear = 1'b0;
    end
  endtask

  task automatic check_ticks(input string name);
    check({name, "_count"}, tick_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < tick_q.size(); i++)
      check({name, "_edge"}, int'(tick_q[i]), int'(exp_q[i]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_chk = 0; n_fail = 0; chk_en = 1'b0;
    rst = 1'b1; btn_run = 1'b0; btn_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_run", int'(run), 0);
    check("rst_clear", int'(clear), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_psc", int'(dut.psc), 0);
    rst = 1'b0;
    chk_en = 1'b1;

    // idle after reset
    obs(0, 0, 50);
    check("idle_run", run_chg, 0);
    check("idle_clear", clr_n, 0);
    check("idle_ticks", tick_q.size(), 0);

    // start: run rises 6 edges after edge 1; ticks on RUN cycles 10/20/30
    obs(20, 0, 40);
    check("start_run_edge", run_chg, 7);
    exp_q = '{8'd16, 8'd26, 8'd36};
    check_ticks("start_ticks");
    check("start_psc", int'(dut.psc), 3);

    // pause with psc landing on 6, then resume: first tick 4 RUN cycles in
    obs(0, 0, 6);
    obs(8, 0, 20);
    check("pause_run_edge", run_chg, 7);
    check("pause_ticks", tick_q.size(), 0);
    check("pause_psc_held", int'(dut.psc), 6);
    obs(8, 0, 20);
    check("resume_run_edge", run_chg, 7);
    exp_q = '{8'd10, 8'd20};
    check_ticks("resume_ticks");
    obs(8, 0, 20);
    check("stop2_run_edge", run_chg, 7);
    check("stop2_psc", int'(dut.psc), 6);

    // clear: 3-cycle glitch ignored, clean press gives one pulse
    obs(0, 3, 15);
    check("glitch_clear", clr_n, 0);
    check("glitch_psc", int'(dut.psc), 6);
    obs(0, 10, 20);
    check("clear_count", clr_n, 1);
    check("clear_edge", clr_at, 7);
    check("clear_run", run_chg, 0);
    check("clear_psc", int'(dut.psc), 0);
    check("clear_state", int'(dut.state), 0);

    // simultaneous presses: from STOP clear wins
    obs(10, 10, 20);
    check("both_stop_clear", clr_n, 1);
    check("both_stop_edge", clr_at, 7);
    check("both_stop_run", run_chg, 0);
    // enter RUN, then simultaneous presses: stop wins, clear dropped
    obs(10, 0, 20);
    check("run2_edge", run_chg, 7);
    obs(10, 10, 20);
    check("both_run_edge", run_chg, 7);
    check("both_run_clear", clr_n, 0);
    check("both_run_psc", int'(dut.psc), 0);

    // asynchronous reset mid-RUN at psc=7
    obs(10, 0, 14);
    check("pre_rst_run", int'(run), 1);
    check("pre_rst_psc", int'(dut.psc), 7);
    rst = 1'b1;
    #1;
    check("async_run", int'(run), 0);
    check("async_tick", int'(tick), 0);
    check("async_clear", int'(clear), 0);
    check("async_psc", int'(dut.psc), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    obs(0, 0, 10);
    check("post_rst_run", run_chg, 0);
    check("post_rst_state", int'(dut.state), 0);
    check("post_rst_psc", int'(dut.psc), 0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: got no end, expected end before 200000");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
